command_response_collect_nip: RTL and testbench

Collects register read responses from the per-submodule command encapsulators of the network input process (descriptor extract at source 0, plus three sibling stages) and serialises them onto a single response channel toward the configuration response packet builder. Each source gets a one-entry pending buffer. A round-robin arbiter drains the pending buffers into one output register. The output register is released with a valid/ready handshake. Responses that arrive while their source's pending buffer is still occupied are dropped and counted.

---
 rtl/command_response_collect_nip.sv | 185 ++++++++++++++++++
 tb/tb_command_response_collect_nip.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/command_response_collect_nip.sv
// Collects register read responses from four command encapsulators and serialises them onto one
// valid/ready response channel. Optional overflow counter enabled by macro RESP_OVERFLOW_CNT_EN.
module command_response_collect_nip (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_src0,
    input  logic        i_wr_src1,
    input  logic        i_wr_src2,
    input  logic        i_wr_src3,
    input  logic [18:0] iv_addr_src0,
    input  logic [18:0] iv_addr_src1,
    input  logic [18:0] iv_addr_src2,
    input  logic [18:0] iv_addr_src3,
    input  logic        i_addr_fixed_src0,
    input  logic        i_addr_fixed_src1,
    input  logic        i_addr_fixed_src2,
    input  logic        i_addr_fixed_src3,
    input  logic [31:0] iv_rdata_src0,
    input  logic [31:0] iv_rdata_src1,
    input  logic [31:0] iv_rdata_src2,
    input  logic [31:0] iv_rdata_src3,
    output logic        o_resp_valid,
    output logic [18:0] ov_resp_addr,
    output logic        o_resp_addr_fixed,
    output logic [31:0] ov_resp_rdata,
    output logic [1:0]  ov_resp_src,
    input  logic        i_resp_ready,
    output logic [15:0] ov_overflow_cnt
);

    logic [3:0]  in_wr;
    logic [18:0] in_addr [4];
    logic [3:0]  in_fixed;
    logic [31:0] in_rdata [4];

    assign in_wr       = {i_wr_src3, i_wr_src2, i_wr_src1, i_wr_src0};
    assign in_addr[0]  = iv_addr_src0;
    assign in_addr[1]  = iv_addr_src1;
    assign in_addr[2]  = iv_addr_src2;
    assign in_addr[3]  = iv_addr_src3;
    assign in_fixed    = {i_addr_fixed_src3, i_addr_fixed_src2, i_addr_fixed_src1, i_addr_fixed_src0};
    assign in_rdata[0] = iv_rdata_src0;
    assign in_rdata[1] = iv_rdata_src1;
    assign in_rdata[2] = iv_rdata_src2;
    assign in_rdata[3] = iv_rdata_src3;

    logic [3:0]  pend_valid_q, pend_valid_d;
    logic [3:0]  pend_fixed_q, pend_fixed_d;
    logic [18:0] pend_addr_q  [4];
    logic [18:0] pend_addr_d  [4];
    logic [31:0] pend_rdata_q [4];
    logic [31:0] pend_rdata_d [4];

    logic        out_valid_q, out_valid_d;
    logic [18:0] out_addr_q, out_addr_d;
    logic        out_fixed_q, out_fixed_d;
    logic [31:0] out_rdata_q, out_rdata_d;
    logic [1:0]  out_src_q, out_src_d;
    logic [1:0]  rr_q, rr_d;

    logic        load_en;
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  search_idx;
    logic [3:0]  ovf_evt;

    // Round-robin search starting at rr; a grant only happens when the output register can load.
    always_comb begin
        load_en    = !out_valid_q || i_resp_ready;
        grant_vld  = 1'b0;
        grant_idx  = 2'd0;
        search_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            search_idx = rr_q + i[1:0];
            if (load_en && !grant_vld && pend_valid_q[search_idx]) begin
                grant_vld = 1'b1;
                grant_idx = search_idx;
            end
        end
    end

    // A source granted this cycle frees its slot, so a same-cycle strobe reloads instead of dropping.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_fixed_d = pend_fixed_q;
        pend_addr_d  = pend_addr_q;
        pend_rdata_d = pend_rdata_q;
        ovf_evt      = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (in_wr[k] && (!pend_valid_q[k] || (grant_vld && grant_idx == k[1:0]))) begin
                pend_valid_d[k] = 1'b1;
                pend_fixed_d[k] = in_fixed[k];
                pend_addr_d[k]  = in_addr[k];
                pend_rdata_d[k] = in_rdata[k];
            end else begin
                if (grant_vld && grant_idx == k[1:0]) begin
                    pend_valid_d[k] = 1'b0;
                end
                if (in_wr[k]) begin
                    ovf_evt[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_fixed_d = out_fixed_q;
        out_rdata_d = out_rdata_q;
        out_src_d   = out_src_q;
        rr_d        = rr_q;
        if (load_en) begin
            out_valid_d = grant_vld;
        end
        if (grant_vld) begin
            out_addr_d  = pend_addr_q[grant_idx];
            out_fixed_d = pend_fixed_q[grant_idx];
            out_rdata_d = pend_rdata_q[grant_idx];
            out_src_d   = grant_idx;
            rr_d        = grant_idx + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_valid_q <= 4'd0;
            pend_fixed_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                pend_addr_q[i]  <= 19'd0;
                pend_rdata_q[i] <= 32'd0;
            end
            out_valid_q <= 1'b0;
            out_addr_q  <= 19'd0;
            out_fixed_q <= 1'b0;
            out_rdata_q <= 32'd0;
            out_src_q   <= 2'd0;
            rr_q        <= 2'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_fixed_q <= pend_fixed_d;
            pend_addr_q  <= pend_addr_d;
            pend_rdata_q <= pend_rdata_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_fixed_q  <= out_fixed_d;
            out_rdata_q  <= out_rdata_d;
            out_src_q    <= out_src_d;
            rr_q         <= rr_d;
        end
    end

    assign o_resp_valid      = out_valid_q;
    assign ov_resp_addr      = out_addr_q;
    assign o_resp_addr_fixed = out_fixed_q;
    assign ov_resp_rdata     = out_rdata_q;
    assign ov_resp_src       = out_src_q;

`ifdef RESP_OVERFLOW_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [2:0]  ovf_sum;
    logic [16:0] cnt_sum;

    always_comb begin
        ovf_sum   = {2'b0, ovf_evt[0]} + {2'b0, ovf_evt[1]} + {2'b0, ovf_evt[2]} + {2'b0, ovf_evt[3]};
        cnt_sum   = {1'b0, ovf_cnt_q} + {14'd0, ovf_sum};
        ovf_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_cnt_q <= 16'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ov_overflow_cnt = ovf_cnt_q;
`else
    logic unused_ovf_evt;
    assign unused_ovf_evt  = ^ovf_evt;
    assign ov_overflow_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_command_response_collect_nip.sv
// Directed bench for command_response_collect_nip: latency, round-robin order, backpressure,
// overflow drop, same-cycle reload and mid-operation reset.
module tb_command_response_collect_nip;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr [4];
    logic [18:0] addr [4];
    logic        fixed [4];
    logic [31:0] rdata [4];
    logic        ready = 1'b1;

    logic        resp_valid;
    logic [18:0] resp_addr;
    logic        resp_fixed;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_src;
    logic [15:0] ovf_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;

`ifdef RESP_OVERFLOW_CNT_EN
    localparam logic [15:0] ONE_DROP = 16'd1;
`else
    localparam logic [15:0] ONE_DROP = 16'd0;
`endif

    always #5 clk = ~clk;

    command_response_collect_nip dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_wr_src0         (wr[0]),
        .i_wr_src1         (wr[1]),
        .i_wr_src2         (wr[2]),
        .i_wr_src3         (wr[3]),
        .iv_addr_src0      (addr[0]),
        .iv_addr_src1      (addr[1]),
        .iv_addr_src2      (addr[2]),
        .iv_addr_src3      (addr[3]),
        .i_addr_fixed_src0 (fixed[0]),
        .i_addr_fixed_src1 (fixed[1]),
        .i_addr_fixed_src2 (fixed[2]),
        .i_addr_fixed_src3 (fixed[3]),
        .iv_rdata_src0     (rdata[0]),
        .iv_rdata_src1     (rdata[1]),
        .iv_rdata_src2     (rdata[2]),
        .iv_rdata_src3     (rdata[3]),
        .o_resp_valid      (resp_valid),
        .ov_resp_addr      (resp_addr),
        .o_resp_addr_fixed (resp_fixed),
        .ov_resp_rdata     (resp_rdata),
        .ov_resp_src       (resp_src),
        .i_resp_ready      (ready),
        .ov_overflow_cnt   (ovf_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [1:0] src, input logic [18:0] a,
                            input logic f, input logic [31:0] d);
        chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_src"},   {62'd0, resp_src}, {62'd0, src});
        chk({tag, "_addr"},  {45'd0, resp_addr}, {45'd0, a});
        chk({tag, "_fixed"}, {63'd0, resp_fixed}, {63'd0, f});
        chk({tag, "_rdata"}, {32'd0, resp_rdata}, {32'd0, d});
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {63'd0, resp_valid}, 64'd0);
    endtask

    task automatic strobe(input int k, input logic [18:0] a, input logic f, input logic [31:0] d);
        wr[k]    = 1'b1;
        addr[k]  = a;
        fixed[k] = f;
        rdata[k] = d;
    endtask

    task automatic clr();
        for (int k = 0; k < 4; k++) wr[k] = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_addr"},  {45'd0, resp_addr}, 64'd0);
        chk({tag, "_fixed"}, {63'd0, resp_fixed}, 64'd0);
        chk({tag, "_rdata"}, {32'd0, resp_rdata}, 64'd0);
        chk({tag, "_src"},   {62'd0, resp_src}, 64'd0);
        chk({tag, "_cnt"},   {48'd0, ovf_cnt}, 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            wr[k] = 1'b0; addr[k] = '0; fixed[k] = 1'b0; rdata[k] = '0;
        end
        exp_cnt = 16'd0;
        repeat (3) tick();
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Single response: visible two cycles after the strobe, for exactly one cycle.
        strobe(0, 19'd0, 1'b1, 32'h0000_1234);
        tick(); clr();
        chk_idle("single_t1");
        tick();
        chk_resp("single_t2", 2'd0, 19'd0, 1'b1, 32'h0000_1234);
        tick();
        chk_idle("single_t3");

        // Simultaneous strobes from rr=0: drained in order 0..3 on consecutive cycles.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) strobe(k, 19'h100 + 19'(k), k[0], 32'hA000_0000 + 32'(k));
        tick(); clr();
        chk_idle("all4_t1");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_resp($sformatf("all4_src%0d", k), k[1:0], 19'h100 + 19'(k), k[0], 32'hA000_0000 + 32'(k));
        end
        tick();
        chk_idle("all4_done");

        // rr wrapped to 0: src0 wins over src3.
        strobe(3, 19'h7FFFF, 1'b1, 32'hB333_3333);
        strobe(0, 19'h00001, 1'b0, 32'hB000_0000);
        tick(); clr();
        tick();
        chk_resp("wrap_first", 2'd0, 19'h00001, 1'b0, 32'hB000_0000);
        tick();
        chk_resp("wrap_second", 2'd3, 19'h7FFFF, 1'b1, 32'hB333_3333);
        tick();
        chk_idle("wrap_done");

        // Backpressure: src1 held stable, then src1 and src2 each appear once.
        ready = 1'b0;
        strobe(1, 19'h11, 1'b0, 32'hC111_1111);
        strobe(2, 19'h22, 1'b1, 32'hC222_2222);
        tick(); clr();
        tick();
        chk_resp("bp_hold0", 2'd1, 19'h11, 1'b0, 32'hC111_1111);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp_hold%0d_src", c + 1), {62'd0, resp_src}, 64'd1);
            chk($sformatf("bp_hold%0d_rdata", c + 1), {32'd0, resp_rdata}, 64'hC111_1111);
        end
        ready = 1'b1;
        tick();
        chk_resp("bp_src2", 2'd2, 19'h22, 1'b1, 32'hC222_2222);
        tick();
        chk_idle("bp_done");
        chk("bp_cnt", {48'd0, ovf_cnt}, {48'd0, exp_cnt});

        // Overflow: output blocked by src0, second src3 strobe is dropped.
        ready = 1'b0;
        strobe(0, 19'h50, 1'b0, 32'hE000_0000);
        tick(); clr();
        tick();
        chk_resp("ovf_block", 2'd0, 19'h50, 1'b0, 32'hE000_0000);
        strobe(3, 19'h33, 1'b0, 32'hD000_0001);
        tick(); clr();
        tick();
        strobe(3, 19'h34, 1'b1, 32'hD000_0002);
        tick(); clr();
        exp_cnt = ONE_DROP;
        chk("ovf_cnt", {48'd0, ovf_cnt}, {48'd0, exp_cnt});
        chk("ovf_still_src0", {62'd0, resp_src}, 64'd0);
        ready = 1'b1;
        tick();
        chk_resp("ovf_first", 2'd3, 19'h33, 1'b0, 32'hD000_0001);
        tick();
        chk_idle("ovf_done");

        // Same-cycle grant and reload on src0: both delivered, no drop.
        strobe(0, 19'h60, 1'b1, 32'hF000_0001);
        tick();
        strobe(0, 19'h61, 1'b0, 32'hF000_0002);
        tick(); clr();
        chk_resp("reload_first", 2'd0, 19'h60, 1'b1, 32'hF000_0001);
        tick();
        chk_resp("reload_second", 2'd0, 19'h61, 1'b0, 32'hF000_0002);
        tick();
        chk_idle("reload_done");
        chk("reload_cnt", {48'd0, ovf_cnt}, {48'd0, exp_cnt});

        // Reset with the output valid and three buffers pending.
        ready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(k, 19'h200 + 19'(k), 1'b1, 32'h9000_0000 + 32'(k));
        tick(); clr();
        tick();
        chk("prereset_valid", {63'd0, resp_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_idle($sformatf("postreset%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
